// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator.
// Holds the base-ISA major opcodes, the immediate-type code and the entry
// record that flows through the head/skid registers.
package imm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Entry fields are sized for the widest legal configuration; the top level
  // slices them down to XLEN / TAG_W on the way out.
  localparam int IMM_MAX_W = 64;
  localparam int TAG_MAX_W = 64;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6,
    IMM_CSR   = 3'd7
  } imm_type_e;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    imm_type_e            imm_type;
    logic                 illegal;
    logic [TAG_MAX_W-1:0] tag;
  } imm_entry_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: purely combinational immediate decoder.
// Ports:
//   insn  - 32-bit instruction word
//   entry - decoded immediate (sign-extended to 64 bits, or zero-extended
//           for shift/CSR forms), type code and illegal flag; tag is zero
// Parameter XLEN only affects the shift-amount width (5 bits for RV32,
// 6 bits for RV64); everything else is extended to 64 bits and the caller
// keeps the low XLEN bits, which are the correct XLEN-wide extension.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] insn,
  output imm_entry_t  entry
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [63:0] imm_i_s;
  logic [63:0] imm_s_s;
  logic [63:0] imm_b_s;
  logic [63:0] imm_u_s;
  logic [63:0] imm_j_s;
  logic [63:0] imm_shamt_s;
  logic [63:0] imm_csr_s;

  assign opcode_s = insn[6:0];
  assign funct3_s = insn[14:12];

  assign imm_i_s     = {{52{insn[31]}}, insn[31:20]};
  assign imm_s_s     = {{52{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b_s     = {{51{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u_s     = {{32{insn[31]}}, insn[31:12], 12'd0};
  assign imm_j_s     = {{43{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
  assign imm_shamt_s = (XLEN == 32) ? {59'd0, insn[24:20]} : {58'd0, insn[25:20]};
  assign imm_csr_s   = {59'd0, insn[19:15]};

  // Opcode/funct3 selection of the immediate form.
  always_comb begin
    entry          = '0;
    entry.imm_type = IMM_NONE;
    entry.illegal  = 1'b0;
    case (opcode_s)
      OP_LOAD, OP_JALR: begin
        entry.imm      = imm_i_s;
        entry.imm_type = IMM_I;
      end
      OP_IMM: begin
        // funct3 001/101 are SLLI/SRLI/SRAI: the field is a shift amount
        if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
          entry.imm      = imm_shamt_s;
          entry.imm_type = IMM_SHAMT;
        end else begin
          entry.imm      = imm_i_s;
          entry.imm_type = IMM_I;
        end
      end
      OP_STORE: begin
        entry.imm      = imm_s_s;
        entry.imm_type = IMM_S;
      end
      OP_BRANCH: begin
        entry.imm      = imm_b_s;
        entry.imm_type = IMM_B;
      end
      OP_LUI, OP_AUIPC: begin
        entry.imm      = imm_u_s;
        entry.imm_type = IMM_U;
      end
      OP_JAL: begin
        entry.imm      = imm_j_s;
        entry.imm_type = IMM_J;
      end
      OP_SYSTEM: begin
        // funct3[2] set selects the CSR*I forms carrying a 5-bit zimm
        if (funct3_s[2]) begin
          entry.imm      = imm_csr_s;
          entry.imm_type = IMM_CSR;
        end else begin
          entry.imm      = 64'd0;
          entry.imm_type = IMM_NONE;
        end
      end
      OP_REG, OP_FENCE: begin
        entry.imm      = 64'd0;
        entry.imm_type = IMM_NONE;
      end
      default: begin
        entry.imm      = 64'd0;
        entry.imm_type = IMM_NONE;
        entry.illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: one-cycle pipelined immediate generator with a 2-entry
// skid buffer (head = output register, skid = one overflow entry).
// Ports:
//   clk, reset (sync, active high), flush_i (drops held entries)
//   in_valid_i / in_ready_o / in_insn_i / in_tag_i   - instruction input
//   out_valid_o / out_ready_i                        - result handshake
//   out_imm_o / out_type_o / out_illegal_o / out_tag_o - result fields
// in_ready_o is a flop (not skid-full), so out_ready_i never reaches it
// combinationally.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DWIDTH = 32,
  parameter int TAG_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWIDTH-1:0] in_insn_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_imm_o,
  output logic [2:0]        out_type_o,
  output logic              out_illegal_o,
  output logic [TAG_W-1:0]  out_tag_o
);

  imm_entry_t dec_s;
  imm_entry_t new_entry_s;
  imm_entry_t head_r;
  imm_entry_t skid_r;
  imm_entry_t head_next_s;
  imm_entry_t skid_next_s;
  logic       head_valid_r;
  logic       skid_valid_r;
  logic       in_ready_r;
  logic       head_valid_next_s;
  logic       skid_valid_next_s;
  logic       accept_s;
  logic       leave_s;
  logic       unused_s;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .insn  (in_insn_i[31:0]),
    .entry (dec_s)
  );

  assign accept_s = in_valid_i & in_ready_r;
  assign leave_s  = head_valid_r & out_ready_i;

  // Attach the pass-through tag to the freshly decoded entry.
  always_comb begin
    new_entry_s     = dec_s;
    new_entry_s.tag = TAG_MAX_W'(in_tag_i);
  end

  // Head/skid next-state: flush wins, then refill head, else spill to skid.
  always_comb begin
    head_next_s       = head_r;
    skid_next_s       = skid_r;
    head_valid_next_s = head_valid_r;
    skid_valid_next_s = skid_valid_r;
    if (flush_i) begin
      head_valid_next_s = 1'b0;
      skid_valid_next_s = 1'b0;
    end else if (!head_valid_r || leave_s) begin
      // Skid full implies in_ready was low, so no accept can collide here.
      if (skid_valid_r) begin
        head_next_s       = skid_r;
        head_valid_next_s = 1'b1;
        skid_valid_next_s = 1'b0;
      end else if (accept_s) begin
        head_next_s       = new_entry_s;
        head_valid_next_s = 1'b1;
      end else begin
        head_valid_next_s = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_next_s       = new_entry_s;
        skid_valid_next_s = 1'b1;
      end else begin
        skid_valid_next_s = skid_valid_r;
      end
    end
  end

  // State registers; in_ready is registered from the next skid state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r       <= '0;
      skid_r       <= '0;
      head_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      head_r       <= head_next_s;
      skid_r       <= skid_next_s;
      head_valid_r <= head_valid_next_s;
      skid_valid_r <= skid_valid_next_s;
      in_ready_r   <= ~skid_valid_next_s;
    end
  end

  assign in_ready_o    = in_ready_r;
  assign out_valid_o   = head_valid_r;
  assign out_imm_o     = head_r.imm[XLEN-1:0];
  assign out_type_o    = head_r.imm_type;
  assign out_illegal_o = head_r.illegal;
  assign out_tag_o     = head_r.tag[TAG_W-1:0];

  // Bits above XLEN / TAG_W / 32 are intentionally not consumed.
  assign unused_s = ^{head_r.imm, head_r.tag, in_insn_i};

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_insn, in_tag;
  logic        rdy32, val32, ill32, rdy64, val64, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic [2:0]  typ32, typ64;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    imm_type_e   typ;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] fired_tag[$];
  int          fired_cyc[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DWIDTH(32), .TAG_W(32)) dut32 (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy32), .in_insn_i(in_insn), .in_tag_i(in_tag),
    .out_valid_o(val32), .out_ready_i(out_ready), .out_imm_o(imm32),
    .out_type_o(typ32), .out_illegal_o(ill32), .out_tag_o(tag32));

  imm_gen_pipe #(.XLEN(64), .DWIDTH(32), .TAG_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy64), .in_insn_i(in_insn), .in_tag_i(in_tag),
    .out_valid_o(val64), .out_ready_i(out_ready), .out_imm_o(imm64),
    .out_type_o(typ64), .out_illegal_o(ill64), .out_tag_o(tag64));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: immediate built from the ISA field definitions as signed numbers.
  function automatic exp_t model(input logic [31:0] insn, input logic [31:0] tag);
    exp_t e;
    longint v;
    logic [12:0] b;
    logic [20:0] j;
    bit shamt;
    v = 0; shamt = 0;
    e.typ = IMM_NONE; e.ill = 1'b0; e.tag = tag;
    case (insn[6:0])
      7'h03, 7'h67: begin v = longint'($signed(insn[31:20])); e.typ = IMM_I; end
      7'h13: begin
        if (insn[14:12] == 3'd1 || insn[14:12] == 3'd5) begin shamt = 1; e.typ = IMM_SHAMT; end
        else begin v = longint'($signed(insn[31:20])); e.typ = IMM_I; end
      end
      7'h23: begin v = longint'($signed({insn[31:25], insn[11:7]})); e.typ = IMM_S; end
      7'h63: begin
        b = {insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
        v = longint'($signed(b)); e.typ = IMM_B;
      end
      7'h37, 7'h17: begin v = longint'($signed(insn[31:12])) * 64'sd4096; e.typ = IMM_U; end
      7'h6F: begin
        j = {insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
        v = longint'($signed(j)); e.typ = IMM_J;
      end
      7'h73: begin
        if (insn[14]) begin v = longint'({59'd0, insn[19:15]}); e.typ = IMM_CSR; end
        else e.typ = IMM_NONE;
      end
      7'h33, 7'h0F: e.typ = IMM_NONE;
      default: e.ill = 1'b1;
    endcase
    e.imm64 = v;
    e.imm32 = e.imm64[31:0];
    if (shamt) begin
      e.imm32 = {27'd0, insn[24:20]};
      e.imm64 = {58'd0, insn[25:20]};
    end
    return e;
  endfunction

  // Scoreboard: in-flight FIFO of at most two entries.
  always @(posedge clk) begin
    bit mrdy;
    cyc++;
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      mrdy = exp_q.size() < 2;
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && mrdy) exp_q.push_back(model(in_insn, in_tag));
    end
  end

  // Compare both DUTs against the scoreboard every cycle out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      chk("valid32", 64'(val32), 64'(exp_q.size() > 0));
      chk("ready32", 64'(rdy32), 64'(exp_q.size() < 2));
      chk("valid64", 64'(val64), 64'(exp_q.size() > 0));
      chk("ready64", 64'(rdy64), 64'(exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        chk("imm32", 64'(imm32), 64'(exp_q[0].imm32));
        chk("imm64", imm64, exp_q[0].imm64);
        chk("type32", 64'(typ32), 64'(exp_q[0].typ));
        chk("type64", 64'(typ64), 64'(exp_q[0].typ));
        chk("ill32", 64'(ill32), 64'(exp_q[0].ill));
        chk("ill64", 64'(ill64), 64'(exp_q[0].ill));
        chk("tag32", 64'(tag32), 64'(exp_q[0].tag));
        chk("tag64", 64'(tag64), 64'(exp_q[0].tag));
      end
      if (val32 && out_ready) begin
        fired_tag.push_back(tag32);
        fired_cyc.push_back(cyc);
      end
    end
  end

  task automatic idle(input int n);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One instruction into an empty pipe; returns at the negedge it is shown.
  task automatic send_one(input logic [31:0] insn, input logic [31:0] tag);
    idle(2);
    in_valid = 1'b1; in_insn = insn; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] r;
    logic [6:0] ops [11];
    ops = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h13, 7'h37, 7'h17, 7'h73, 7'h33, 7'h0F};
    r = $urandom;
    if ($urandom_range(0, 9) < 8) r[6:0] = ops[$urandom_range(0, 10)];
    return r;
  endfunction

  initial begin
    exp_t m;
    bit done;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_insn = 32'hFFF00093; in_tag = 32'h5555;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(val32), 64'd0);
    chk("rst_ready", 64'(rdy32), 64'd1);
    chk("rst_imm", 64'(imm32), 64'd0);
    chk("rst_type", 64'(typ32), 64'(IMM_NONE));
    chk("rst_ill", 64'(ill32), 64'd0);
    chk("rst_tag", 64'(tag32), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;

    // Hand-computed pins of the reference model.
    m = model(32'hFFF00093, 32'h100);
    chk("pin_addi", m.imm32, 64'hFFFFFFFF);
    m = model(32'hFE000EE3, 32'h0);
    chk("pin_beq", m.imm32, 64'hFFFFFFFC);
    m = model(32'h800000B7, 32'h0);
    chk("pin_lui64", m.imm64, 64'hFFFFFFFF80000000);

    // Directed decode cases through the DUTs.
    send_one(32'hFFF00093, 32'h100);
    chk("addi_imm", 64'(imm32), 64'hFFFFFFFF);
    chk("addi_type", 64'(typ32), 64'(IMM_I));
    chk("addi_tag", 64'(tag32), 64'h100);
    chk("addi_valid", 64'(val32), 64'd1);
    send_one(32'hFE000EE3, 32'h104);
    chk("beq_imm", 64'(imm32), 64'hFFFFFFFC);
    chk("beq_type", 64'(typ32), 64'(IMM_B));
    send_one(32'h01F09093, 32'h108);
    chk("slli_imm", 64'(imm32), 64'h1F);
    chk("slli_type", 64'(typ32), 64'(IMM_SHAMT));
    send_one(32'h3002D073, 32'h10C);
    chk("csr_imm", 64'(imm32), 64'h5);
    chk("csr_type", 64'(typ32), 64'(IMM_CSR));
    send_one(32'h800000B7, 32'h110);
    chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
    chk("lui_imm32", 64'(imm32), 64'h80000000);
    chk("lui_type", 64'(typ64), 64'(IMM_U));
    send_one(32'h0000007F, 32'h114);
    chk("bad_ill", 64'(ill32), 64'd1);
    chk("bad_imm", 64'(imm32), 64'd0);
    chk("bad_type", 64'(typ32), 64'(IMM_NONE));
    send_one(32'h00000033, 32'h118);
    chk("add_ill", 64'(ill32), 64'd0);

    // Back-pressure: A held, B in skid, C refused until space frees.
    idle(2);
    fired_tag.delete(); fired_cyc.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_insn = 32'h00100093; in_tag = 32'hA;
    @(posedge clk); #1; in_insn = 32'h00200093; in_tag = 32'hB;
    @(posedge clk); #1; in_insn = 32'h00300093; in_tag = 32'hC;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_ready", 64'(rdy32), 64'd0);
    chk("bp_valid", 64'(val32), 64'd1);
    chk("bp_head", 64'(tag32), 64'hA);
    @(posedge clk); #1; out_ready = 1'b1;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() < 2) begin
        @(posedge clk); #1; in_valid = 1'b0; done = 1;
      end
    end
    chk("bp_c_accepted", 64'(done), 64'd1);
    repeat (4) @(posedge clk);
    chk("bp_count", 64'(fired_tag.size()), 64'd3);
    if (fired_tag.size() == 3) begin
      chk("bp_order0", 64'(fired_tag[0]), 64'hA);
      chk("bp_order1", 64'(fired_tag[1]), 64'hB);
      chk("bp_order2", 64'(fired_tag[2]), 64'hC);
      chk("bp_consec", 64'(fired_cyc[2] - fired_cyc[0]), 64'd2);
    end

    // Flush with two held entries plus a new input.
    idle(2);
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'h20;
    @(posedge clk); #1; in_tag = 32'h21;
    @(posedge clk); #1; in_tag = 32'h22; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush2_valid", 64'(val32), 64'd0);
    chk("flush2_ready", 64'(rdy32), 64'd1);
    // Flush with one held entry while the input is acceptable.
    idle(2);
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'h30;
    @(posedge clk); #1; in_tag = 32'h31; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush1_valid", 64'(val32), 64'd0);
    @(negedge clk);
    chk("flush1_dropped", 64'(val32), 64'd0);

    // Reset mid-stream, then first-transfer latency.
    idle(2);
    out_ready = 1'b0; in_valid = 1'b1; in_insn = 32'hFFF00093; in_tag = 32'h40;
    @(posedge clk); #1; in_tag = 32'h41;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mrst_valid", 64'(val32), 64'd0);
    chk("mrst_ready", 64'(rdy32), 64'd1);
    chk("mrst_imm", 64'(imm32), 64'd0);
    chk("mrst_tag", 64'(tag32), 64'd0);
    chk("mrst_ill", 64'(ill32), 64'd0);
    @(posedge clk); #1; reset = 1'b0; in_tag = 32'h42;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(val32), 64'd1);
    chk("post_rst_tag", 64'(tag32), 64'h42);

    // Randomized traffic with stalls and occasional flushes.
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      in_insn   = rand_insn();
      in_tag    = $urandom;
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 3);
      @(posedge clk); #1;
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one instruction per cycle over a valid/ready handshake and produces a sign- or zero-extended immediate of width XLEN, an immediate-type code and an illegal-opcode flag one cycle later. Unlike a purely combinational immediate unit, it adds shift-amount and CSR zimm forms, a pass-through tag, and a 2-entry skid buffer so back-pressure from execute never creates a combinational ready path.

## Interface
- XLEN, 32, immediate output width; legal values 32 or 64.
- DWIDTH, 32, instruction width.
- TAG_W, 32, width of the pass-through tag (normally the PC).

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  drop all held entries
- in_valid_i  in  1  instruction valid
- in_ready_o  out  1  block can accept this cycle
- in_insn_i  in  DWIDTH  instruction word
- in_tag_i  in  TAG_W  tag carried alongside the instruction
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts
- out_imm_o  out  XLEN  extended immediate
- out_type_o  out  3  imm_type_e code
- out_illegal_o  out  1  opcode not recognised
- out_tag_o  out  TAG_W  tag of this result

## Operation
- Decode uses opcode = insn[6:0] and funct3 = insn[14:12]. All sign extension replicates insn[31] up to XLEN.
- IMM_I, for 0000011, 1100111 and 0010011 (except shifts): sign-extend insn[31:20].
- IMM_SHAMT, for 0010011 with funct3 001 or 101: zero-extend insn[24:20] when XLEN=32, or insn[25:20] when XLEN=64.
- IMM_S, for 0100011: sign-extend {insn[31:25], insn[11:7]}.
- IMM_B, for 1100011: sign-extend {insn[31], insn[7], insn[30:25], insn[11:8], 0}.
- IMM_U, for 0110111 and 0010111: {insn[31:12], 12'b0}, sign-extended to XLEN.
- IMM_J, for 1101111: sign-extend {insn[31], insn[19:12], insn[20], insn[30:21], 0}.
- IMM_CSR, for 1110011 with funct3[2]=1: zero-extend insn[19:15].
- IMM_NONE, for 0110011, 0001111, and 1110011 with funct3[2]=0: imm = 0, not illegal.
- Any other opcode: IMM_NONE, imm = 0, out_illegal_o = 1.

Handshakes:
- A transfer occurs when valid and ready are both high on a rising edge.
- The output register holds the head entry; the skid register holds one overflow entry.
- in_ready_o = !skid_valid, a registered value with no combinational path from out_ready_i.
- Accept while head is empty, or head is leaving: the new entry loads the head.
- Accept while head is full and stalled: the new entry loads skid.
- Head leaves while skid is full: skid moves to head, and in_ready_o returns to 1 the next cycle.
- Output fields hold stable while out_valid_o=1 and out_ready_i=0.
- Flush has priority over accept and advance: both entries are invalidated next cycle, and a same-cycle input is discarded.

## Timing
- Latency is 1 cycle from input transfer to out_valid_o, with no bubble.
- Throughput is 1 per cycle while out_ready_i=1.
- Reset values:
  - out_valid_o=0, out_imm_o=0, out_type_o=IMM_NONE, out_illegal_o=0, out_tag_o=0.
  - Skid buffer empty, so in_ready_o=1.
  - Inputs presented while reset is high are ignored.
- Reset mid-stream drops both entries; the first valid after reset deasserts arrives 1 cycle after the first accept.
- A stall lasting any number of cycles loses no data; at most 2 entries are in flight.
- Simultaneous head-leave and accept with skid empty: the head is replaced and skid stays empty.

## Structure
- Shared package imm_pkg holds:
  - the opcode localparams: OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_IMM, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_REG, OP_FENCE;
  - typedef enum logic [2:0] imm_type_e {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_CSR};
  - a packed struct imm_entry_t {imm, type, illegal, tag}.
- Sub-module imm_decode is purely combinational (insn in, imm_entry_t out, XLEN parameter). The top level holds the head and skid registers and the handshake logic.

## Test plan
- Basic sign extension: XLEN=32, insn 0xFFF00093 (addi x1,x0,-1), tag 0x100 -> next cycle valid, imm 0xFFFFFFFF, type IMM_I, tag 0x100.
- Branch, shift and CSR forms:
  - insn 0xFE000EE3 (beq -4) -> imm 0xFFFFFFFC, IMM_B.
  - insn 0x01F09093 (slli x1,x1,31) -> imm 0x1F, IMM_SHAMT.
  - insn 0x3002D073 (csrrwi x0,mstatus,5) -> imm 0x5, IMM_CSR.
- 64-bit mode: XLEN=64, insn 0x800000B7 (lui x1,0x80000) -> imm 0xFFFFFFFF80000000, IMM_U.
- Illegal opcode: insn 0x0000007F -> imm 0, IMM_NONE, illegal=1; insn 0x00000033 -> illegal=0.
- Back-pressure:
  - Stream A, B, C with out_ready_i=0 from cycle 1 -> A held, B in skid, in_ready_o=0, C not accepted.
  - Then out_ready_i=1 -> A, B, C emerge in order on consecutive cycles with no loss or duplicate.
- Flush and reset:
  - flush_i with 2 entries held plus a new input -> out_valid_o=0 next cycle, in_ready_o=1, input dropped.
  - reset mid-stream -> all outputs at reset values.
